mul_unit: RTL and testbench

- Pipelined RV32M multiply execution stage wrapped around the combinational unsigned core mul32.
- Upstream: sign preprocessing into operand magnitudes and a negate flag. Downstream: 64-bit sign fixup and lo/hi selection.
- Sits between the decode/issue stage and writeback.
- Uses valid/ready handshakes on both sides, a tag pass-through, and a flush.

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_unit_mul32.sv | 17 +
 rtl/mul_unit.sv | 143 ++++++++++++++
 tb/tb_mul_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the RV32M multiply stage: operand width, op encodings
// and the conditional two's-complement helper used for sign preprocessing.
package mul_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  // 0x80000000 negates to itself, which is the correct magnitude as unsigned.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic en);
    return en ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_unit_mul32.sv
// mul32: combinational 32x32 -> 64-bit unsigned multiplier core.
module mul32
  import mul_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] hi
);

  logic [2*XLEN-1:0] p;

  assign p  = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
  assign lo = p[XLEN-1:0];
  assign hi = p[2*XLEN-1:XLEN];

endmodule

// File: rtl/mul_unit.sv
// mul_unit: two-stage RV32M multiply (MUL/MULH/MULHSU/MULHU) with valid/ready,
// tag pass-through and flush. Define MUL_PERF_EN to add the perf_cnt accept counter.
module mul_unit
  import mul_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_res,
  output logic [TAG_W-1:0] out_tag
`ifdef MUL_PERF_EN
  ,
  output logic [31:0]      perf_cnt
`endif
);

  // S1: operand magnitudes and the result-negate flag
  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [XLEN-1:0]  s1_mag_a_q, s1_mag_a_d;
  logic [XLEN-1:0]  s1_mag_b_q, s1_mag_b_d;
  logic             s1_neg_q, s1_neg_d;

  // S2: selected result, presented directly on the output ports
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_res_q, out_res_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             s1_en, s2_en, accept;
  logic             a_neg, b_neg;
  logic [XLEN-1:0]  p_lo, p_hi;
  logic [2*XLEN-1:0] r;

  mul32 u_mul32 (
    .a  (s1_mag_a_q),
    .b  (s1_mag_b_q),
    .lo (p_lo),
    .hi (p_hi)
  );

  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en && !flush;
  assign accept   = in_valid && in_ready;

  assign a_neg = in_a[XLEN-1] && (in_op == MUL_OP_MULH || in_op == MUL_OP_MULHSU);
  assign b_neg = in_b[XLEN-1] && (in_op == MUL_OP_MULH);
  assign r     = s1_neg_q ? (~{p_hi, p_lo} + 64'd1) : {p_hi, p_lo};

  // NOTE: every always_comb output gets a hold default first so no path leaves it unassigned (no latch).
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_tag_d    = s1_tag_q;
    s1_mag_a_d  = s1_mag_a_q;
    s1_mag_b_d  = s1_mag_b_q;
    s1_neg_d    = s1_neg_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_tag_d   = out_tag_q;

    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (s2_en) begin
        out_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          out_res_d = (s1_op_q == MUL_OP_MUL) ? r[XLEN-1:0] : r[2*XLEN-1:XLEN];
          out_tag_d = s1_tag_q;
        end
      end
      // Clearing s1_valid when S1 drains without a new accept collapses bubbles.
      if (s1_en) begin
        s1_valid_d = accept;
        if (accept) begin
          s1_op_d    = in_op;
          s1_tag_d   = in_tag;
          s1_mag_a_d = cond_neg(in_a, a_neg);
          s1_mag_b_d = cond_neg(in_b, b_neg);
          s1_neg_d   = a_neg ^ b_neg;
        end
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= 2'b00;
      s1_tag_q    <= '0;
      s1_mag_a_q  <= '0;
      s1_mag_b_q  <= '0;
      s1_neg_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_tag_q    <= s1_tag_d;
      s1_mag_a_q  <= s1_mag_a_d;
      s1_mag_b_q  <= s1_mag_b_d;
      s1_neg_q    <= s1_neg_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_tag   = out_tag_q;

`ifdef MUL_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  // Counts accepts, so ops later flushed are still included; wraps naturally.
  always_comb begin
    perf_cnt_d = perf_cnt_q + {31'd0, accept};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_cnt_q <= '0;
    else     perf_cnt_q <= perf_cnt_d;
  end

  assign perf_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_mul_unit.sv
// Directed self-checking bench for mul_unit: latency, back-to-back, stall,
// flush, async reset and (with MUL_PERF_EN) the accept counter.
module tb_mul_unit;
  import mul_pkg::*;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_res;
  logic [TAG_W-1:0] out_tag;
`ifdef MUL_PERF_EN
  logic [31:0]      perf_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [TAG_W+31:0] exp_q[$];

  mul_unit #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag)
`ifdef MUL_PERF_EN
    ,
    .perf_cnt  (perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [TAG_W-1:0] tag, input logic [31:0] res);
    exp_q.push_back({tag, res});
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: each output handshake must match the next expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_result", {27'd0, out_tag, out_res}, 64'd0);
      end else begin
        check("result", {27'd0, out_tag, out_res}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_res",   64'(out_res),   64'd0);
    check("rst_out_tag",   64'(out_tag),   64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Latency: accept at edge A, out_valid visible after edge A+1.
    drive(MUL_OP_MUL, 32'd5, 32'd6, 5'd3);
    push(5'd3, 32'h0000001E);
    tick();
    idle();
    check("lat_a_valid", 64'(out_valid), 64'd0);
    tick();
    check("lat_b_valid", 64'(out_valid), 64'd1);
    check("lat_b_res",   64'(out_res),   64'h1E);
    check("lat_b_tag",   64'(out_tag),   64'd3);
    tick();
    check("lat_c_valid", 64'(out_valid), 64'd0);
    drain(4);

    // Back-to-back, one op per cycle
    begin
      logic [1:0]  ops [6] = '{MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU,
                               MUL_OP_MULH, MUL_OP_MUL, MUL_OP_MULH};
      logic [31:0] as  [6] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
      logic [31:0] bs  [6] = '{32'h80000000, 32'h00000002, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
      logic [31:0] rs  [6] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE,
                               32'h00000000, 32'h00000001, 32'hFFFFFFFF};
      for (int i = 0; i < 6; i++) begin
        drive(ops[i], as[i], bs[i], TAG_W'(10 + i));
        push(TAG_W'(10 + i), rs[i]);
        tick();
        if (i > 0) check("b2b_valid", 64'(out_valid), 64'd1);
      end
      idle();
      tick();
      check("b2b_last_valid", 64'(out_valid), 64'd1);
      drain(6);
    end

    // Back-pressure: S2 then S1 fill, in_ready drops, outputs hold.
    out_ready = 1'b0;
    drive(MUL_OP_MULHU, 32'h00010000, 32'h00010000, 5'd20);
    push(5'd20, 32'h00000001);
    #1 check("bp_rdy1", 64'(in_ready), 64'd1);
    tick();
    drive(MUL_OP_MUL, 32'h12345678, 32'h00000010, 5'd21);
    push(5'd21, 32'h23456780);
    #1 check("bp_rdy2", 64'(in_ready), 64'd1);
    tick();
    drive(MUL_OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 5'd22);
    push(5'd22, 32'h80000000);
    #1 check("bp_rdy3", 64'(in_ready), 64'd0);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_res0",  64'(out_res),   64'h1);
    for (int i = 0; i < 2; i++) begin
      tick();
      #1 check("bp_hold_rdy", 64'(in_ready), 64'd0);
      check("bp_hold_res", 64'(out_res), 64'h1);
      check("bp_hold_tag", 64'(out_tag), 64'd20);
    end
    out_ready = 1'b1;
    #1 check("bp_release_rdy", 64'(in_ready), 64'd1);
    tick();
    idle();
    drain(8);

    // Flush with both stages full and a new op offered
    out_ready = 1'b0;
    drive(MUL_OP_MUL, 32'd11, 32'd11, 5'd1);
    tick();
    drive(MUL_OP_MUL, 32'd12, 32'd12, 5'd2);
    tick();
    drive(MUL_OP_MUL, 32'd13, 32'd13, 5'd4);
    flush = 1'b1;
    #1 check("fl_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    idle();
    check("fl_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    tick();
    check("fl_s1_empty", 64'(out_valid), 64'd0);
    drive(MUL_OP_MUL, 32'd7, 32'd9, 5'd9);
    push(5'd9, 32'd63);
    tick();
    idle();
    drain(6);

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    drive(MUL_OP_MUL, 32'h100, 32'h100, 5'd4);
    tick();
    idle();
    tick();
    check("ar_pre_res", 64'(out_res), 64'h10000);
    #2 rst = 1'b1;
    #1 check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_res",   64'(out_res),  64'd0);
    check("ar_tag",   64'(out_tag),  64'd0);
    check("ar_ready", 64'(in_ready), 64'd1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("ar_flushed", 64'(out_valid), 64'd0);
    drive(MUL_OP_MUL, 32'd2, 32'd3, 5'd6);
    push(5'd6, 32'd6);
    tick();
    idle();
    drain(6);

`ifdef MUL_PERF_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("perf_rst", 64'(perf_cnt), 64'd0);
    drive(MUL_OP_MUL, 32'd99, 32'd99, 5'd0);
    tick();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      drive(MUL_OP_MUL, 32'(i), 32'(i), TAG_W'(i));
      push(TAG_W'(i), 32'(i * i));
      tick();
    end
    idle();
    drain(6);
    check("perf_cnt", 64'(perf_cnt), 64'd10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
